// File: rtl/console_text_buffer_if.sv
// console_text_buffer_if: byte-stream write port, raster read port and cursor status
interface console_text_buffer_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;
  logic [7:0] wr_attribute;
  logic [9:0] cx;
  logic [9:0] cy;
  logic [7:0] codepoint;
  logic [7:0] attribute;
  logic [6:0] cursor_col;
  logic [4:0] cursor_row;
  modport master (
    output wr_valid, wr_char, wr_attribute, cx, cy,
    input  wr_ready, codepoint, attribute, cursor_col, cursor_row
  );
  modport slave (
    input  wr_valid, wr_char, wr_attribute, cx, cy,
    output wr_ready, codepoint, attribute, cursor_col, cursor_row
  );
endinterface

// File: rtl/console_text_buffer.sv
// console_text_buffer: terminal-semantics character cell store with a fixed two-cycle raster read port
module console_text_buffer #(
  parameter int         COLUMNS    = 80,
  parameter int         ROWS       = 30,
  parameter logic [7:0] CLEAR_ATTR = 8'h0F
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  console_text_buffer_if.slave bus
);
  localparam int CELLS = COLUMNS * ROWS;
  localparam int AW = $clog2(CELLS);
  localparam logic [15:0] BLANK = {CLEAR_ATTR, 8'h20};
  typedef enum logic [1:0] {INIT_CLEAR, IDLE, SCROLL_CLEAR} state_t;
  state_t         state_q, state_d;
  logic [AW-1:0]  clr_q, clr_d, waddr, raddr_q, raddr_d;
  logic [6:0]     col_q, col_d;
  logic [4:0]     row_q, row_d, top_q, top_d;
  logic           we, adv, vis, vis0_q, vis1_q;
  logic [15:0]    wdata, cell_q;
  logic [15:0]    mem [CELLS];
  // Logical row rotated by the circular top pointer; one compare-subtract replaces a modulo
  function automatic logic [4:0] phys(input logic [4:0] r, input logic [4:0] t);
    logic [5:0] s;
    s = {1'b0, r} + {1'b0, t};
    return (s >= 6'(ROWS)) ? 5'(s - 6'(ROWS)) : s[4:0];
  endfunction
  // During SCROLL_CLEAR the cursor sits on the bottom logical row, which maps to the old top
  assign waddr = (state_q == INIT_CLEAR) ? clr_q
               : AW'(phys(row_q, top_q)) * AW'(COLUMNS) + ((state_q == IDLE) ? AW'(col_q) : clr_q);
  assign vis = (bus.cx < 10'(COLUMNS * 8)) && (bus.cy < 10'(ROWS * 16));
  assign raddr_d = vis ? AW'(phys(bus.cy[8:4], top_q)) * AW'(COLUMNS) + AW'(bus.cx[9:3]) : '0;
  assign {bus.attribute, bus.codepoint} = vis1_q ? cell_q : 16'h0020;
  assign bus.wr_ready = state_q == IDLE;
  assign bus.cursor_col = col_q;
  assign bus.cursor_row = row_q;
  // Clear sequencing, byte interpretation and cursor/scroll bookkeeping
  always_comb begin
    state_d = state_q;
    clr_d = clr_q;
    col_d = col_q;
    row_d = row_q;
    top_d = top_q;
    we = 1'b0;
    adv = 1'b0;
    wdata = BLANK;
    case (state_q)
      INIT_CLEAR: begin
        we = 1'b1;
        clr_d = (clr_q == AW'(CELLS - 1)) ? '0 : clr_q + 1'b1;
        state_d = (clr_q == AW'(CELLS - 1)) ? IDLE : INIT_CLEAR;
      end
      SCROLL_CLEAR: begin
        we = 1'b1;
        clr_d = (clr_q == AW'(COLUMNS - 1)) ? '0 : clr_q + 1'b1;
        state_d = (clr_q == AW'(COLUMNS - 1)) ? IDLE : SCROLL_CLEAR;
      end
      default: if (bus.wr_valid) begin
        if (bus.wr_char == 8'h0A) begin
          col_d = '0;
          adv = 1'b1;
        end else if (bus.wr_char == 8'h0D) begin
          col_d = '0;
        end else if (bus.wr_char == 8'h08) begin
          col_d = (col_q != '0) ? col_q - 7'd1 : col_q;
        end else begin
          we = 1'b1;
          wdata = {bus.wr_attribute, bus.wr_char};
          adv = col_q == 7'(COLUMNS - 1);
          col_d = adv ? '0 : col_q + 7'd1;
        end
        if (adv && row_q != 5'(ROWS - 1)) row_d = row_q + 5'd1;
        if (adv && row_q == 5'(ROWS - 1)) begin
          top_d = (top_q == 5'(ROWS - 1)) ? '0 : top_q + 5'd1;
          state_d = SCROLL_CLEAR;
          clr_d = '0;
        end
      end
    endcase
  end
  // Control state and the two read-pipeline qualifier stages
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q <= INIT_CLEAR;
      clr_q <= '0;
      col_q <= '0;
      row_q <= '0;
      top_q <= '0;
      raddr_q <= '0;
      vis0_q <= 1'b0;
      vis1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q <= clr_d;
      col_q <= col_d;
      row_q <= row_d;
      top_q <= top_d;
      raddr_q <= raddr_d;
      vis0_q <= vis;
      vis1_q <= vis0_q;
    end
  end
  // Dual-port cell RAM; the registered read sees pre-write contents on an address collision
  always_ff @(posedge clk_pixel) begin
    if (we) mem[waddr] <= wdata;
    cell_q <= mem[raddr_q];
  end
endmodule

// File: tb/tb_console_text_buffer.sv
// tb_console_text_buffer: randomized raster/byte stimulus against a logical-screen model with a read scoreboard
module tb_console_text_buffer;
  logic clk_pixel = 1'b0;
  logic reset = 1'b1;
  always #5 clk_pixel = ~clk_pixel;
  console_text_buffer_if bus();
  console_text_buffer dut (.clk_pixel(clk_pixel), .reset(reset), .bus(bus));
  typedef struct {int due; int x; int y; logic [15:0] exp;} rd_t;
  rd_t sbq[$];
  int dir_x[$], dir_y[$];
  logic [15:0] scr [30][80];
  int mc, mr, checks, failures, cyc;
  bit rast_en;
  always @(posedge clk_pixel) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask
  function automatic logic [15:0] exp_cell(input int x, input int y);
    return (x < 640 && y < 480) ? scr[y / 16][x / 8] : 16'h0020;
  endfunction
  task automatic model_clear();
    for (int r = 0; r < 30; r++) for (int c = 0; c < 80; c++) scr[r][c] = 16'h0F20;
    mc = 0;
    mr = 0;
  endtask
  task automatic model_adv(output bit sc);
    sc = 0;
    if (mr < 29) mr++;
    else begin
      for (int r = 0; r < 29; r++) scr[r] = scr[r + 1];
      for (int c = 0; c < 80; c++) scr[29][c] = 16'h0F20;
      sc = 1;
    end
  endtask
  task automatic model_byte(input logic [7:0] ch, input logic [7:0] a, output bit sc);
    sc = 0;
    if (ch == 8'h0A) begin mc = 0; model_adv(sc); end
    else if (ch == 8'h0D) mc = 0;
    else if (ch == 8'h08) begin if (mc > 0) mc--; end
    else begin
      scr[mr][mc] = {a, ch};
      mc++;
      if (mc == 80) begin mc = 0; model_adv(sc); end
    end
  endtask
  initial begin : drv
    int x, y;
    rd_t it;
    forever begin
      @(posedge clk_pixel); #1;
      if (rast_en) begin
        if (dir_x.size() > 0) begin x = dir_x.pop_front(); y = dir_y.pop_front(); end
        else if ($urandom_range(3) == 0) begin x = $urandom_range(1023); y = $urandom_range(1023); end
        else begin x = $urandom_range(639); y = $urandom_range(479); end
        bus.cx = 10'(x);
        bus.cy = 10'(y);
        it.due = cyc + 2; it.x = x; it.y = y; it.exp = exp_cell(x, y);
        sbq.push_back(it);
      end
    end
  end
  initial begin : mon
    rd_t r;
    forever begin
      @(posedge clk_pixel); #1;
      while (sbq.size() > 0 && sbq[0].due <= cyc) begin
        r = sbq.pop_front();
        checks++;
        if ({bus.attribute, bus.codepoint} !== r.exp || r.due != cyc) begin
          failures++;
          $display("FAIL raster cx=%0d cy=%0d got=%h expected=%h", r.x, r.y, {bus.attribute, bus.codepoint}, r.exp);
        end
      end
    end
  end
  task automatic raster(input int n);
    rast_en = 1;
    repeat (n) @(posedge clk_pixel);
    #1 rast_en = 0;
    repeat (4) @(posedge clk_pixel);
    #2;
    chk("raster_drain", sbq.size(), 0);
  endtask
  task automatic peek(input string name, input int x, input int y, input logic [15:0] exp);
    bus.cx = 10'(x);
    bus.cy = 10'(y);
    repeat (2) @(posedge clk_pixel);
    #1;
    chk(name, {bus.attribute, bus.codepoint}, exp);
  endtask
  task automatic send(input logic [7:0] ch, input logic [7:0] a, input bit stall_chk = 1);
    int n = 0;
    bit sc;
    bus.wr_valid = 1;
    bus.wr_char = ch;
    bus.wr_attribute = a;
    while (!bus.wr_ready && n < 5000) begin @(posedge clk_pixel); #1; n++; end
    if (n >= 5000) begin checks++; failures++; $display("FAIL wr_ready_timeout got=0 expected=1"); end
    @(posedge clk_pixel); #1;
    bus.wr_valid = 0;
    model_byte(ch, a, sc);
    chk("cursor_col", bus.cursor_col, mc);
    chk("cursor_row", bus.cursor_row, mr);
    if (sc && stall_chk) begin
      n = 0;
      while (!bus.wr_ready && n < 200) begin @(posedge clk_pixel); #1; n++; end
      chk("scroll_stall", n, 80);
    end
  endtask
  task automatic do_reset();
    int n = 0;
    rast_en = 0;
    @(posedge clk_pixel);
    #3 reset = 1;
    #1;
    chk("rst_wr_ready", bus.wr_ready, 0);
    chk("rst_cursor_col", bus.cursor_col, 0);
    chk("rst_cursor_row", bus.cursor_row, 0);
    chk("rst_codepoint", bus.codepoint, 8'h20);
    chk("rst_attribute", bus.attribute, 8'h00);
    @(posedge clk_pixel); #1;
    reset = 0;
    sbq.delete();
    model_clear();
    while (!bus.wr_ready && n < 3000) begin @(posedge clk_pixel); #1; n++; end
    chk("init_clear_cycles", n, 2400);
  endtask
  initial begin
    int r;
    logic [7:0] c;
    bus.wr_valid = 0; bus.wr_char = 0; bus.wr_attribute = 0; bus.cx = 0; bus.cy = 0;
    do_reset();
    dir_x = '{0, 639, 632, 0, 8, 640, 0};
    dir_y = '{0, 479, 0, 464, 16, 0, 480};
    raster(200);
    send(8'h41, 8'h1E);
    chk("t2_col", bus.cursor_col, 1);
    peek("t2_cell00", 0, 0, 16'h1E41);
    peek("t2_cell10", 8, 0, 16'h0F20);
    send(8'h0D, 8'h00);
    repeat (81) send(8'h78, 8'h07);
    chk("t3_col", bus.cursor_col, 1);
    chk("t3_row", bus.cursor_row, 1);
    peek("t3_row0_last", 632, 0, 16'h0778);
    peek("t3_cell01", 0, 16, 16'h0778);
    peek("t3_cell11", 8, 16, 16'h0F20);
    for (int i = 0; i < 80; i++) begin dir_x.push_back(i * 8 + 3); dir_y.push_back(5); end
    raster(100);
    peek("t5_cx700", 700, 0, 16'h0020);
    peek("t5_cy490", 0, 490, 16'h0020);
    send(8'h0D, 8'h00);
    send(8'h08, 8'h00);
    chk("t5_bs_col0", bus.cursor_col, 0);
    send(8'h61, 8'h2A);
    send(8'h62, 8'h2B);
    send(8'h08, 8'h00);
    chk("t5_bs_col", bus.cursor_col, 1);
    peek("t5_bs_kept", 8, 16, 16'h2B62);
    do_reset();
    send(8'h5A, 8'h1E);
    repeat (30) send(8'h0A, 8'h00);
    chk("t4_row", bus.cursor_row, 29);
    peek("t4_z_gone", 0, 0, 16'h0F20);
    for (int i = 0; i < 80; i++) begin dir_x.push_back(i * 8); dir_y.push_back(29 * 16 + 15); end
    raster(100);
    repeat (400) begin
      r = $urandom_range(99);
      c = (r < 8) ? 8'h0A : (r < 11) ? 8'h0D : (r < 15) ? 8'h08 : 8'($urandom_range(255));
      send(c, 8'($urandom_range(255)));
    end
    raster(600);
    bus.cx = 0;
    bus.cy = 0;
    while (mr < 29) send(8'h0A, 8'h07);
    send(8'h0A, 8'h07, 0);
    repeat (10) @(posedge clk_pixel);
    #1;
    chk("t6_mid_scroll", bus.wr_ready, 0);
    do_reset();
    raster(150);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
